// File: rtl/s_spi_slave_param.sv
// -----------------------------------------------------------------------------
// s_spi_slave_param
// Parametrised SPI slave core. The word width, clock polarity/phase and bit order
// are set by parameters. A one-deep transmit buffer with a valid/ready handshake
// feeds the tx shift register. The core supports back-to-back words within a
// single SS assertion. It reports an underrun when a word is loaded with no data
// buffered, and a frame error when SS rises in the middle of a word.
//
// Ports
//   clk        system clock; all logic runs in this domain
//   reset      asynchronous, active-low reset
//   SCLK       SPI clock from the master (asynchronous, synchronized here)
//   MOSI       master-out data (asynchronous, synchronized here)
//   SS         slave select, active-low (asynchronous, synchronized here)
//   MISO       slave-out data
//   tx_data    next word to transmit
//   tx_valid   tx_data is valid
//   tx_ready   transmit buffer is empty; a write occurs on tx_valid && tx_ready
//   rx_data    last completed received word
//   rx_valid   one-cycle pulse when rx_data updates
//   busy       frame in progress
//   underrun   one-cycle pulse when IDLE_WORD is loaded into the tx register
//   frame_err  one-cycle pulse when SS rises with a partial word
// -----------------------------------------------------------------------------
module s_spi_slave_param #(
    parameter int unsigned WIDTH     = 64,
    parameter bit          CPOL      = 1'b0,
    parameter bit          CPHA      = 1'b0,
    parameter bit          MSB_FIRST = 1'b1,
    parameter logic [63:0] IDLE_WORD = 64'h3333333366666666
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             SCLK,
    input  logic             MOSI,
    input  logic             SS,
    output logic             MISO,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             underrun,
    output logic             frame_err
);

    localparam int unsigned CNT_W  = $clog2(WIDTH + 1);
    localparam int unsigned TX_BIT = MSB_FIRST ? (WIDTH - 1) : 0;
    localparam logic [WIDTH-1:0] IDLE_W = IDLE_WORD[WIDTH-1:0];

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Two synchronizer stages plus one history stage per pin; bit 0 is the first flop.
    logic [2:0] sclk_q;
    logic [2:0] mosi_q;
    logic [2:0] ss_q;

    state_e             state_q,     state_d;
    logic [CNT_W-1:0]   bit_cnt_q,   bit_cnt_d;
    logic               sampled_q,   sampled_d;
    logic [WIDTH-1:0]   tx_sr_q,     tx_sr_d;
    logic [WIDTH-1:0]   rx_sr_q,     rx_sr_d;
    logic [WIDTH-1:0]   buf_q,       buf_d;
    logic               tx_ready_q,  tx_ready_d;
    logic [WIDTH-1:0]   rx_data_q,   rx_data_d;
    logic               rx_valid_q,  rx_valid_d;
    logic               busy_q,      busy_d;
    logic               underrun_q,  underrun_d;
    logic               frame_err_q, frame_err_d;
    logic               miso_q,      miso_d;

    logic               sclk_rise_c;
    logic               sclk_fall_c;
    logic               sample_edge_c;
    logic               shift_edge_c;
    logic               ss_fall_c;
    logic               ss_rise_c;
    logic               mosi_s_c;

    // Pin synchronizers. SS resets low, so if SS is already low when reset releases,
    // the core sees no fall until SS has gone high and then low again.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_q <= {3{CPOL}};
            mosi_q <= '0;
            ss_q   <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], SCLK};
            mosi_q <= {mosi_q[1:0], MOSI};
            ss_q   <= {ss_q[1:0], SS};
        end
    end

    // Edge decode from the synchronized SCLK and SS.
    always_comb begin
        sclk_rise_c   = sclk_q[1] & ~sclk_q[2];
        sclk_fall_c   = ~sclk_q[1] & sclk_q[2];
        sample_edge_c = (CPOL ^ CPHA) ? sclk_fall_c : sclk_rise_c;
        shift_edge_c  = (CPOL ^ CPHA) ? sclk_rise_c : sclk_fall_c;
        ss_fall_c     = ~ss_q[1] & ss_q[2];
        ss_rise_c     = ss_q[1] & ~ss_q[2];
        mosi_s_c      = mosi_q[1];
    end

    // Next-state logic for the frame FSM, the shift registers and the tx buffer.
    always_comb begin
        logic             load;
        logic [CNT_W-1:0] cnt_next;
        logic [WIDTH-1:0] rx_next;

        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        sampled_d   = sampled_q;
        tx_sr_d     = tx_sr_q;
        rx_sr_d     = rx_sr_q;
        buf_d       = buf_q;
        tx_ready_d  = tx_ready_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        underrun_d  = 1'b0;
        frame_err_d = 1'b0;
        load        = 1'b0;
        cnt_next    = bit_cnt_q;
        rx_next     = rx_sr_q;

        case (state_q)
            ST_IDLE: begin
                bit_cnt_d = '0;
                sampled_d = 1'b0;
                if (ss_fall_c) begin
                    state_d = ST_SHIFT;
                    load    = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (sample_edge_c) begin
                    rx_next = MSB_FIRST ? {rx_sr_q[WIDTH-2:0], mosi_s_c}
                                        : {mosi_s_c, rx_sr_q[WIDTH-1:1]};
                    rx_sr_d = rx_next;
                    if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
                        rx_data_d  = rx_next;
                        rx_valid_d = 1'b1;
                        cnt_next   = '0;
                        sampled_d  = 1'b0;
                        // When SS rises on this same edge, the frame is ending, so the buffer is not consumed.
                        load       = ~ss_rise_c;
                    end else begin
                        cnt_next  = bit_cnt_q + CNT_W'(1);
                        sampled_d = 1'b1;
                    end
                end else if (shift_edge_c && sampled_q) begin
                    // Gating on the sampled flag makes the core hold the first bit (CPHA=1)
                    // and hold the freshly reloaded bit after a word completes (CPHA=0).
                    tx_sr_d = MSB_FIRST ? (tx_sr_q << 1) : (tx_sr_q >> 1);
                end
                bit_cnt_d = cnt_next;
                // The sample on this edge has been taken above, so the SS rise is evaluated against the updated count.
                if (ss_rise_c) begin
                    state_d     = ST_IDLE;
                    frame_err_d = (cnt_next != '0);
                    bit_cnt_d   = '0;
                    sampled_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A load sees the buffer as registered, so a write in the same cycle is held for the next load.
        if (load) begin
            if (!tx_ready_q) begin
                tx_sr_d    = buf_q;
                tx_ready_d = 1'b1;
            end else begin
                tx_sr_d    = IDLE_W;
                underrun_d = 1'b1;
            end
        end

        if (tx_valid && tx_ready_q) begin
            buf_d      = tx_data;
            tx_ready_d = 1'b0;
        end

        busy_d = (state_d == ST_SHIFT);
        miso_d = (state_d == ST_SHIFT) ? tx_sr_d[TX_BIT] : 1'b0;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            sampled_q   <= 1'b0;
            tx_sr_q     <= '0;
            rx_sr_q     <= '0;
            buf_q       <= '0;
            tx_ready_q  <= 1'b1;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            underrun_q  <= 1'b0;
            frame_err_q <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            sampled_q   <= sampled_d;
            tx_sr_q     <= tx_sr_d;
            rx_sr_q     <= rx_sr_d;
            buf_q       <= buf_d;
            tx_ready_q  <= tx_ready_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            busy_q      <= busy_d;
            underrun_q  <= underrun_d;
            frame_err_q <= frame_err_d;
            miso_q      <= miso_d;
        end
    end

    assign MISO      = miso_q;
    assign tx_ready  = tx_ready_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign busy      = busy_q;
    assign underrun  = underrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_s_spi_slave_param.sv
// -----------------------------------------------------------------------------
// tb_s_spi_slave_param
// Bench for two instances of the slave: mode 0 / 64-bit / MSB first, and
// CPOL=1 CPHA=1 / 16-bit / LSB first. A behavioural SPI master drives each one.
// A word-level model of the tx buffer predicts MISO words, underruns, received
// words and frame errors.
// -----------------------------------------------------------------------------
module tb_s_spi_slave_param;

    localparam int          HALF  = 5;
    localparam int          W0    = 64;
    localparam int          W1    = 16;
    localparam bit          CPOL0 = 1'b0, CPHA0 = 1'b0, MSB0 = 1'b1;
    localparam bit          CPOL1 = 1'b1, CPHA1 = 1'b1, MSB1 = 1'b0;
    localparam logic [63:0] IDLE  = 64'h3333333366666666;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        sclk [2];
    logic        mosi [2];
    logic        ss   [2];
    logic        txv  [2];
    logic [63:0] txd  [2];

    logic        miso0, miso1, txr0, txr1, rxv0, rxv1;
    logic        busy0, busy1, und0, und1, fe0, fe1;
    logic [63:0] rxd0;
    logic [15:0] rxd1;

    s_spi_slave_param #(.WIDTH(W0), .CPOL(CPOL0), .CPHA(CPHA0), .MSB_FIRST(MSB0), .IDLE_WORD(IDLE)) u_dut0 (
        .clk(clk), .reset(rst_n), .SCLK(sclk[0]), .MOSI(mosi[0]), .SS(ss[0]), .MISO(miso0),
        .tx_data(txd[0]), .tx_valid(txv[0]), .tx_ready(txr0), .rx_data(rxd0), .rx_valid(rxv0),
        .busy(busy0), .underrun(und0), .frame_err(fe0));

    s_spi_slave_param #(.WIDTH(W1), .CPOL(CPOL1), .CPHA(CPHA1), .MSB_FIRST(MSB1), .IDLE_WORD(IDLE)) u_dut1 (
        .clk(clk), .reset(rst_n), .SCLK(sclk[1]), .MOSI(mosi[1]), .SS(ss[1]), .MISO(miso1),
        .tx_data(txd[1][15:0]), .tx_valid(txv[1]), .tx_ready(txr1), .rx_data(rxd1), .rx_valid(rxv1),
        .busy(busy1), .underrun(und1), .frame_err(fe1));

    int n_chk = 0;
    int n_err = 0;

    // Observed pulse counts and received words.
    int          n_rxv [2];
    int          n_und [2];
    int          n_fe  [2];
    logic [63:0] rxq0 [$];
    logic [63:0] rxq1 [$];

    // Reference model state.
    bit          mfull [2];
    logic [63:0] mbuf  [2];
    int          e_rxv [2];
    int          e_und [2];
    int          e_fe  [2];
    logic [63:0] e_rx  [2];

    logic [63:0] m_words  [8];
    logic [63:0] wr_words [8];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int wof(input int idx);       return (idx == 0) ? W0 : W1;                   endfunction
    function automatic bit cpol_of(input int idx);   return (idx == 0) ? CPOL0 : CPOL1;             endfunction
    function automatic bit cpha_of(input int idx);   return (idx == 0) ? CPHA0 : CPHA1;             endfunction
    function automatic bit msb_of(input int idx);    return (idx == 0) ? MSB0 : MSB1;               endfunction
    function automatic logic [63:0] mask_of(input int idx); return (idx == 0) ? '1 : 64'h0000_0000_0000_FFFF; endfunction
    function automatic logic get_miso(input int idx); return (idx == 0) ? miso0 : miso1;            endfunction
    function automatic logic get_txr(input int idx);  return (idx == 0) ? txr0 : txr1;              endfunction
    function automatic logic get_busy(input int idx); return (idx == 0) ? busy0 : busy1;            endfunction
    function automatic logic [63:0] get_rxd(input int idx); return (idx == 0) ? rxd0 : {48'h0, rxd1}; endfunction

    always @(negedge clk) begin
        if (rxv0) begin n_rxv[0]++; rxq0.push_back(rxd0); end
        if (rxv1) begin n_rxv[1]++; rxq1.push_back({48'h0, rxd1}); end
        if (und0) n_und[0]++;
        if (und1) n_und[1]++;
        if (fe0)  n_fe[0]++;
        if (fe1)  n_fe[1]++;
    end

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model: each word load takes the buffered word, or IDLE_WORD when the buffer is empty.
    task automatic mdl_load(input int idx, output logic [63:0] w);
        if (mfull[idx]) begin
            mfull[idx] = 1'b0;
            w = mbuf[idx];
        end else begin
            e_und[idx]++;
            w = IDLE & mask_of(idx);
        end
    endtask

    task automatic do_write(input int idx, input logic [63:0] w);
        chk("tx_ready_pre_write", {63'h0, get_txr(idx)}, {63'h0, ~mfull[idx]});
        txv[idx] = 1'b1;
        txd[idx] = w & mask_of(idx);
        wclk(1);
        txv[idx] = 1'b0;
        if (!mfull[idx]) begin
            mfull[idx] = 1'b1;
            mbuf[idx]  = w & mask_of(idx);
        end
    endtask

    // One SCLK period in the instance's mode; returns the MISO bit seen at the sample edge.
    task automatic bit_cycle(input int idx, input logic bout, output logic bin);
        bit cpol;
        cpol = cpol_of(idx);
        if (!cpha_of(idx)) begin
            mosi[idx] = bout;
            wclk(HALF);
            sclk[idx] = ~cpol;
            bin = get_miso(idx);
            wclk(HALF);
            sclk[idx] = cpol;
        end else begin
            sclk[idx] = ~cpol;
            mosi[idx] = bout;
            wclk(HALF);
            sclk[idx] = cpol;
            bin = get_miso(idx);
            wclk(HALF);
        end
    endtask

    // One SS frame of nw words. If partial is nonzero, the last word stops after that many bits.
    // When wmask[k] is set, wr_words[k] is written during word k.
    task automatic xfer(input int idx, input int nw, input int partial, input logic [7:0] wmask);
        logic [63:0] exp_tx [9];
        logic [63:0] s, v;
        logic        b;
        int          w, nb, pos, nfull;
        bit          ok;
        w = wof(idx);
        nfull = 0;
        ss[idx] = 1'b0;
        mdl_load(idx, exp_tx[0]);
        wclk(6);
        chk("busy_in_frame", {63'h0, get_busy(idx)}, 64'd1);
        chk("underrun_at_start", 64'(n_und[idx]), 64'(e_und[idx]));
        for (int k = 0; k < nw; k++) begin
            nb = (k == nw - 1 && partial != 0) ? partial : w;
            s = '0;
            for (int i = 0; i < nb; i++) begin
                if (i == 2 && wmask[k]) do_write(idx, wr_words[k]);
                pos = msb_of(idx) ? (w - 1 - i) : i;
                bit_cycle(idx, m_words[k][pos], b);
                s[pos] = b;
            end
            if (nb == w) begin
                chk("miso_word", s, exp_tx[k]);
                nfull++;
                e_rxv[idx]++;
                e_rx[idx] = m_words[k] & mask_of(idx);
                mdl_load(idx, exp_tx[k + 1]);
            end else begin
                e_fe[idx]++;
            end
        end
        wclk(HALF);
        ss[idx] = 1'b1;
        wclk(8);
        for (int k = 0; k < nfull; k++) begin
            ok = 1'b1;
            v  = '0;
            if (idx == 0) begin
                if (rxq0.size() == 0) ok = 1'b0; else v = rxq0.pop_front();
            end else begin
                if (rxq1.size() == 0) ok = 1'b0; else v = rxq1.pop_front();
            end
            chk("rx_word_present", {63'h0, ok}, 64'd1);
            if (ok) chk("rx_word", v, m_words[k] & mask_of(idx));
        end
        if (idx == 0) rxq0.delete(); else rxq1.delete();
        chk("rx_valid_count",  64'(n_rxv[idx]), 64'(e_rxv[idx]));
        chk("underrun_count",  64'(n_und[idx]), 64'(e_und[idx]));
        chk("frame_err_count", 64'(n_fe[idx]),  64'(e_fe[idx]));
        chk("rx_data_hold",    get_rxd(idx), e_rx[idx]);
        chk("tx_ready_after",  {63'h0, get_txr(idx)}, {63'h0, ~mfull[idx]});
        chk("busy_after",      {63'h0, get_busy(idx)}, 64'd0);
        chk("miso_idle",       {63'h0, get_miso(idx)}, 64'd0);
    endtask

    task automatic rand_frame(input int idx, input int maxw);
        int nw;
        nw = $urandom_range(1, maxw);
        for (int k = 0; k < nw; k++) begin
            m_words[k]  = {$urandom, $urandom} & mask_of(idx);
            wr_words[k] = {$urandom, $urandom} & mask_of(idx);
        end
        if ($urandom_range(0, 1) == 1) do_write(idx, {$urandom, $urandom});
        xfer(idx, nw, 0, 8'($urandom));
    endtask

    task automatic chk_reset_outputs(input int idx);
        chk("rst_miso",      {63'h0, get_miso(idx)}, 64'd0);
        chk("rst_rx_data",   get_rxd(idx), 64'd0);
        chk("rst_rx_valid",  {63'h0, (idx == 0) ? rxv0 : rxv1}, 64'd0);
        chk("rst_tx_ready",  {63'h0, get_txr(idx)}, 64'd1);
        chk("rst_busy",      {63'h0, get_busy(idx)}, 64'd0);
        chk("rst_underrun",  {63'h0, (idx == 0) ? und0 : und1}, 64'd0);
        chk("rst_frame_err", {63'h0, (idx == 0) ? fe0 : fe1}, 64'd0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mfull[i] = 1'b0;
            mbuf[i]  = '0;
            e_rx[i]  = '0;
        end
    endtask

    initial begin
        #800us;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic b;
        for (int i = 0; i < 2; i++) begin
            sclk[i] = cpol_of(i);
            mosi[i] = 1'b0;
            ss[i]   = 1'b1;
            txv[i]  = 1'b0;
            txd[i]  = '0;
            n_rxv[i] = 0; n_und[i] = 0; n_fe[i] = 0;
            e_rxv[i] = 0; e_und[i] = 0; e_fe[i] = 0;
        end
        model_reset();
        rst_n = 1'b0;
        wclk(3);
        chk_reset_outputs(0);
        chk_reset_outputs(1);
        rst_n = 1'b1;
        wclk(5);

        // Buffer empty at SS fall: IDLE_WORD is sent and underrun pulses.
        m_words[0] = {$urandom, $urandom};
        xfer(0, 1, 0, 8'h00);

        // Mode 0 directed frame with a preloaded word.
        do_write(0, 64'h0123456789ABCDEF);
        m_words[0]  = 64'hA5A5_0000_FFFF_1234;
        wr_words[0] = {$urandom, $urandom};
        xfer(0, 1, 0, 8'h01);

        // A write while the buffer is full is ignored.
        do_write(0, 64'hFEDC_BA98_7654_3210);
        do_write(0, 64'h1);
        m_words[0] = {$urandom, $urandom};
        xfer(0, 1, 0, 8'h00);

        // SS rises after 10 bits, then a full frame follows.
        m_words[0] = {$urandom, $urandom};
        xfer(0, 1, 10, 8'h00);
        m_words[0] = {$urandom, $urandom};
        xfer(0, 1, 0, 8'h00);

        // CPOL=1, CPHA=1, 16-bit, LSB first, two words in one frame.
        do_write(1, 64'hBEEF);
        m_words[0]  = 64'h00F1;
        m_words[1]  = 64'h8002;
        wr_words[0] = 64'hCAFE;
        xfer(1, 2, 0, 8'h01);

        for (int r = 0; r < 8; r++) rand_frame(1, 3);
        for (int r = 0; r < 3; r++) rand_frame(0, 2);
        m_words[0] = {$urandom, $urandom};
        xfer(1, 1, 7, 8'h00);

        // Reset during bit 30 of a frame, with SS held low through the release.
        do_write(0, {$urandom, $urandom});
        ss[0] = 1'b0;
        mdl_load(0, m_words[7]);
        wclk(6);
        for (int i = 0; i < 30; i++) bit_cycle(0, 1'($urandom), b);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs(0);
        chk_reset_outputs(1);
        model_reset();
        wclk(3);
        rst_n = 1'b1;
        wclk(6);
        for (int i = 0; i < 70; i++) bit_cycle(0, 1'($urandom), b);
        chk("no_rx_valid_stale_ss", 64'(n_rxv[0]), 64'(e_rxv[0]));
        chk("no_busy_stale_ss",     {63'h0, busy0}, 64'd0);
        chk("rx_data_after_rst",    rxd0, 64'd0);
        ss[0] = 1'b1;
        wclk(8);
        rxq0.delete();

        for (int r = 0; r < 2; r++) rand_frame(0, 1);
        for (int r = 0; r < 3; r++) rand_frame(1, 2);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
